// File: rtl/zip_pkt_scheduler.sv
// Two-source packet scheduler: packs four 8-bit IQ symbols per output word and
// grants one source at a time for a configurable burst of packets.
module zip_pkt_scheduler #(
    parameter int MAX_BURST = 15,
    localparam int BW = $clog2(MAX_BURST + 1)
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic [BW-1:0] cfg_burst,
    input  logic [31:0]   s0_tdata,
    input  logic          s0_tlast,
    input  logic          s0_tvalid,
    output logic          s0_tready,
    input  logic [31:0]   s1_tdata,
    input  logic          s1_tlast,
    input  logic          s1_tvalid,
    output logic          s1_tready,
    output logic [31:0]   o_tdata,
    output logic          o_tlast,
    output logic          o_tvalid,
    input  logic          o_tready,
    output logic          o_tdest,
    output logic [1:0]    o_grant,
    output logic [1:0]    state_dbg
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PACK  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t        state, state_nxt;
    logic          grant_src;
    logic          last_src;
    logic [BW-1:0] burst_cnt;
    logic [1:0]    idx;
    logic [31:0]   word_buf;

    logic          sel_valid, sel_last;
    logic [31:0]   sel_data;
    logic [7:0]    sym;
    logic [31:0]   sym_word, buf_nxt;
    logic          out_free, accept, close_word, burst_done;
    logic          any_req, pref_valid, pick;

    // A transfer happens on a rising edge where valid and ready are both high;
    // valid never waits for ready, and output data holds while valid & ~ready.
    always_comb begin
        sel_valid  = grant_src ? s1_tvalid : s0_tvalid;
        sel_last   = grant_src ? s1_tlast  : s0_tlast;
        sel_data   = grant_src ? s1_tdata  : s0_tdata;
        sym        = {sel_data[31:28], sel_data[15:12]};
        out_free   = ~o_tvalid | o_tready;
        accept     = (state == PACK) && out_free && sel_valid;
        close_word = accept && (sel_last || idx == 2'd3);
        burst_done = accept && sel_last && (burst_cnt == BW'(1));
        any_req    = s0_tvalid | s1_tvalid;
        // Alternate: prefer whichever source was not served last.
        pref_valid = last_src ? s0_tvalid : s1_tvalid;
        pick       = pref_valid ? ~last_src : last_src;
        case (idx)
            2'd0:    sym_word = {sym, 24'd0};
            2'd1:    sym_word = {8'd0, sym, 16'd0};
            2'd2:    sym_word = {16'd0, sym, 8'd0};
            default: sym_word = {24'd0, sym};
        endcase
        buf_nxt = word_buf | sym_word;
    end

    always_comb begin
        state_nxt = state;
        s0_tready = 1'b0;
        s1_tready = 1'b0;
        case (state)
            IDLE: begin
                if (any_req) state_nxt = PACK;
            end
            PACK: begin
                s0_tready = ~grant_src & out_free;
                s1_tready = grant_src & out_free;
                if (burst_done) state_nxt = DRAIN;
            end
            DRAIN: begin
                if (out_free) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign state_dbg = state;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            grant_src <= 1'b0;
            last_src  <= 1'b1;
            o_grant   <= 2'b00;
            burst_cnt <= '0;
            idx       <= 2'd0;
            word_buf  <= 32'd0;
            o_tdata   <= 32'd0;
            o_tlast   <= 1'b0;
            o_tvalid  <= 1'b0;
            o_tdest   <= 1'b0;
        end else begin
            if (state == IDLE && any_req) begin
                grant_src <= pick;
                o_grant   <= pick ? 2'b10 : 2'b01;
                burst_cnt <= (cfg_burst == '0) ? BW'(1) : cfg_burst;
                idx       <= 2'd0;
            end
            if (state == DRAIN && out_free) begin
                last_src <= grant_src;
                o_grant  <= 2'b00;
            end
            if (accept) begin
                if (close_word) begin
                    word_buf <= 32'd0;
                    idx      <= 2'd0;
                end else begin
                    word_buf <= buf_nxt;
                    idx      <= idx + 2'd1;
                end
                if (sel_last) burst_cnt <= burst_cnt - BW'(1);
            end
            // Unwritten bytes are already zero in word_buf when tlast closes early.
            if (close_word) begin
                o_tdata  <= buf_nxt;
                o_tlast  <= sel_last;
                o_tdest  <= grant_src;
                o_tvalid <= 1'b1;
            end else if (o_tready) begin
                o_tvalid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_zip_pkt_scheduler.sv
// Bench for zip_pkt_scheduler: table vectors, directed corner sequences and
// randomized two-source traffic checked against a packet-level model.
module tb_zip_pkt_scheduler;

    localparam int MAX_BURST = 15;
    localparam int BW = $clog2(MAX_BURST + 1);

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [BW-1:0] cfg_burst = '0;
    logic [31:0]   s0_tdata = 32'd0, s1_tdata = 32'd0;
    logic          s0_tlast = 1'b0, s1_tlast = 1'b0;
    logic          s0_tvalid = 1'b0, s1_tvalid = 1'b0;
    logic          s0_tready, s1_tready;
    logic [31:0]   o_tdata;
    logic          o_tlast, o_tvalid, o_tdest;
    logic          o_tready = 1'b0;
    logic [1:0]    o_grant;
    logic [1:0]    state_dbg;

    zip_pkt_scheduler #(.MAX_BURST(MAX_BURST)) dut (
        .clk(clk), .reset_n(reset_n), .cfg_burst(cfg_burst),
        .s0_tdata(s0_tdata), .s0_tlast(s0_tlast), .s0_tvalid(s0_tvalid), .s0_tready(s0_tready),
        .s1_tdata(s1_tdata), .s1_tlast(s1_tlast), .s1_tvalid(s1_tvalid), .s1_tready(s1_tready),
        .o_tdata(o_tdata), .o_tlast(o_tlast), .o_tvalid(o_tvalid), .o_tready(o_tready),
        .o_tdest(o_tdest), .o_grant(o_grant), .state_dbg(state_dbg)
    );

    // Clock
    always #5 clk = ~clk;

    typedef struct {
        logic        src;
        logic [3:0]  burst;
        int          len;
        logic [63:0] bytes;
        int          nw;
        logic [63:0] words;
        logic [1:0]  lasts;
    } vec_t;

    vec_t        vecs[7];
    logic [32:0] src_q0[$], src_q1[$];
    logic [33:0] exp_q[$];
    logic [7:0]  pkt_b[$];
    logic [7:0]  pb0[$], pb1[$];
    int          pl0[$], pl1[$];

    int          n_cmp, n_err, cyc, rdy_pct, hold_cnt;
    int          acc0, first_acc0, last_acc0;
    bit          bubbles, at_start0, at_start1, stall_prev;
    logic [33:0] prev_word;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%h required=%h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    function automatic logic [32:0] mk(input logic [7:0] b, input logic last);
        logic [11:0] r1, r2;
        r1 = 12'($urandom);
        r2 = 12'($urandom);
        return {last, b[7:4], r1, b[3:0], r2};
    endfunction

    task automatic load_pkt(input logic src);
        for (int i = 0; i < pkt_b.size(); i++) begin
            if (src) src_q1.push_back(mk(pkt_b[i], i == pkt_b.size() - 1));
            else     src_q0.push_back(mk(pkt_b[i], i == pkt_b.size() - 1));
        end
    endtask

    // Reference packing: bytes fill MSB first, four per word, last word zero-padded.
    task automatic expect_pkt(input logic src);
        int n;
        logic [31:0] word;
        n = pkt_b.size();
        for (int w = 0; w * 4 < n; w++) begin
            word = 32'd0;
            for (int k = 0; k < 4; k++)
                if (w * 4 + k < n) word[31 - 8 * k -: 8] = pkt_b[w * 4 + k];
            exp_q.push_back({src, (w * 4 + 4 >= n), word});
        end
    endtask

    task automatic gen_pkts(input logic src, input int npk);
        int len;
        for (int p = 0; p < npk; p++) begin
            len = $urandom_range(1, 9);
            pkt_b.delete();
            for (int i = 0; i < len; i++) pkt_b.push_back(8'($urandom));
            load_pkt(src);
            if (src) begin
                pl1.push_back(len);
                foreach (pkt_b[i]) pb1.push_back(pkt_b[i]);
            end else begin
                pl0.push_back(len);
                foreach (pkt_b[i]) pb0.push_back(pkt_b[i]);
            end
        end
    endtask

    // Grant order: the source not served last wins if it has packets; each grant
    // carries eff packets of that source.
    task automatic model_run(input int eff);
        int p0, p1, o0, o1;
        logic last, pref, pick;
        p0 = 0; p1 = 0; o0 = 0; o1 = 0;
        last = 1'b1;
        while (p0 < pl0.size() || p1 < pl1.size()) begin
            pref = ~last;
            pick = ((pref == 1'b0 && p0 < pl0.size()) || (pref == 1'b1 && p1 < pl1.size())) ? pref : ~pref;
            for (int k = 0; k < eff; k++) begin
                pkt_b.delete();
                if (pick == 1'b0 && p0 < pl0.size()) begin
                    for (int i = 0; i < pl0[p0]; i++) pkt_b.push_back(pb0[o0 + i]);
                    o0 += pl0[p0];
                    p0++;
                    expect_pkt(1'b0);
                end else if (pick == 1'b1 && p1 < pl1.size()) begin
                    for (int i = 0; i < pl1[p1]; i++) pkt_b.push_back(pb1[o1 + i]);
                    o1 += pl1[p1];
                    p1++;
                    expect_pkt(1'b1);
                end
            end
            last = pick;
        end
    endtask

    // One cycle: drive at negedge, sample handshakes 1 ns later.
    task automatic step();
        @(negedge clk);
        cyc++;
        if (hold_cnt > 0) begin
            o_tready = 1'b0;
            hold_cnt--;
        end else begin
            o_tready = ($urandom_range(99) < rdy_pct);
        end
        if (src_q0.size() == 0) s0_tvalid = 1'b0;
        else begin
            s0_tdata  = src_q0[0][31:0];
            s0_tlast  = src_q0[0][32];
            s0_tvalid = !(bubbles && !at_start0 && $urandom_range(3) == 0);
        end
        if (src_q1.size() == 0) s1_tvalid = 1'b0;
        else begin
            s1_tdata  = src_q1[0][31:0];
            s1_tlast  = src_q1[0][32];
            s1_tvalid = !(bubbles && !at_start1 && $urandom_range(3) == 0);
        end
        #1;
        check("tready_excl", 64'(s0_tready & s1_tready), 64'd0);
        check("tready_grant", 64'((s0_tready & ~o_grant[0]) | (s1_tready & ~o_grant[1])), 64'd0);
        if (stall_prev)
            check("stall_hold", {o_tvalid, o_tdest, o_tlast, o_tdata}, {1'b1, prev_word});
        stall_prev = o_tvalid & ~o_tready;
        prev_word  = {o_tdest, o_tlast, o_tdata};
        if (s0_tvalid && s0_tready) begin
            at_start0 = src_q0[0][32];
            void'(src_q0.pop_front());
            acc0++;
            if (first_acc0 < 0) first_acc0 = cyc;
            last_acc0 = cyc;
        end
        if (s1_tvalid && s1_tready) begin
            at_start1 = src_q1[0][32];
            void'(src_q1.pop_front());
        end
        if (o_tvalid && o_tready) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL extra_word actual=%h required=none at cycle %0d",
                         {o_tdest, o_tlast, o_tdata}, cyc);
            end else begin
                check("out_word", {o_tdest, o_tlast, o_tdata}, exp_q.pop_front());
            end
        end
    endtask

    task automatic run_done(input int budget, input string tag);
        int n;
        n = 0;
        while ((src_q0.size() != 0 || src_q1.size() != 0 || exp_q.size() != 0) && n < budget) begin
            step();
            n++;
        end
        check({tag, "_timeout"}, 64'(n >= budget), 64'd0);
        repeat (4) step();
        check({tag, "_grant_idle"}, {o_grant, o_tvalid}, 64'd0);
    endtask

    // Asynchronous assertion mid-cycle; outputs must clear before any edge.
    task automatic do_reset();
        #2;
        reset_n   = 1'b0;
        s0_tvalid = 1'b0;
        s1_tvalid = 1'b0;
        src_q0.delete(); src_q1.delete(); exp_q.delete();
        pl0.delete(); pl1.delete(); pb0.delete(); pb1.delete();
        at_start0 = 1'b1; at_start1 = 1'b1;
        stall_prev = 1'b0; hold_cnt = 0;
        #1;
        check("reset_outs", {o_tvalid, o_tlast, o_tdest, o_grant, s0_tready, s1_tready, o_tdata}, 64'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        int n, b, eff;
        n_cmp = 0; n_err = 0; cyc = 0; hold_cnt = 0;
        rdy_pct = 100; bubbles = 1'b0;
        acc0 = 0; first_acc0 = -1; last_acc0 = 0;
        at_start0 = 1'b1; at_start1 = 1'b1; stall_prev = 1'b0; prev_word = '0;

        vecs[0] = '{src: 1'b0, burst: 4'd1, len: 8, bytes: 64'hA5A5A5A5_A5A5A5A5, nw: 2, words: 64'hA5A5A5A5_A5A5A5A5, lasts: 2'b01};
        vecs[1] = '{src: 1'b1, burst: 4'd1, len: 6, bytes: 64'h11223344_55660000, nw: 2, words: 64'h11223344_55660000, lasts: 2'b01};
        vecs[2] = '{src: 1'b0, burst: 4'd0, len: 1, bytes: 64'h3C000000_00000000, nw: 1, words: 64'h3C000000_00000000, lasts: 2'b10};
        vecs[3] = '{src: 1'b1, burst: 4'd1, len: 4, bytes: 64'hDEADBEEF_00000000, nw: 1, words: 64'hDEADBEEF_00000000, lasts: 2'b10};
        vecs[4] = '{src: 1'b0, burst: 4'd1, len: 5, bytes: 64'h01020304_05000000, nw: 2, words: 64'h01020304_05000000, lasts: 2'b01};
        vecs[5] = '{src: 1'b1, burst: 4'd0, len: 3, bytes: 64'hF00F8800_00000000, nw: 1, words: 64'hF00F8800_00000000, lasts: 2'b10};
        vecs[6] = '{src: 1'b0, burst: 4'd1, len: 7, bytes: 64'h10203040_50607000, nw: 2, words: 64'h10203040_50607000, lasts: 2'b01};

        do_reset();
        step();
        check("idle_after_reset", {o_grant, o_tvalid, s0_tready, s1_tready}, 64'd0);

        // Table vectors
        for (int v = 0; v < 7; v++) begin
            logic [63:0] tb_t, tw_t;
            cfg_burst = BW'(vecs[v].burst);
            pkt_b.delete();
            for (int i = 0; i < vecs[v].len; i++) begin
                tb_t = vecs[v].bytes << (8 * i);
                pkt_b.push_back(tb_t[63:56]);
            end
            load_pkt(vecs[v].src);
            for (int w = 0; w < vecs[v].nw; w++) begin
                tw_t = vecs[v].words << (32 * w);
                exp_q.push_back({vecs[v].src, vecs[v].lasts[1 - w], tw_t[63:32]});
            end
            run_done(200, "vec");
        end

        // Both sources requesting, burst of 2: s0,s0 then s1,s1
        do_reset();
        cfg_burst = BW'(2);
        pkt_b = '{8'h0A}; load_pkt(1'b0);
        pkt_b = '{8'h0B}; load_pkt(1'b0);
        pkt_b = '{8'h0C}; load_pkt(1'b1);
        pkt_b = '{8'h0D}; load_pkt(1'b1);
        exp_q.push_back({1'b0, 1'b1, 32'h0A000000});
        exp_q.push_back({1'b0, 1'b1, 32'h0B000000});
        exp_q.push_back({1'b1, 1'b1, 32'h0C000000});
        exp_q.push_back({1'b1, 1'b1, 32'h0D000000});
        run_done(200, "burst2");

        // cfg_burst=0 releases the grant after one packet
        do_reset();
        cfg_burst = '0;
        gen_pkts(1'b0, 2);
        gen_pkts(1'b1, 1);
        model_run(1);
        run_done(300, "burst0");

        // Output stall for 5 cycles with a word pending
        cfg_burst = BW'(1);
        pkt_b.delete();
        for (int i = 0; i < 12; i++) pkt_b.push_back(8'($urandom));
        load_pkt(1'b0);
        expect_pkt(1'b0);
        rdy_pct = 0;
        n = 0;
        while (!o_tvalid && n < 30) begin
            step();
            n++;
        end
        check("stall_setup_timeout", 64'(n >= 30), 64'd0);
        rdy_pct = 100;
        hold_cnt = 5;
        for (int i = 0; i < 5; i++) begin
            step();
            check("stall_tready", {s0_tready, o_tvalid}, 64'b01);
        end
        step();
        check("resume", {o_tvalid, o_tready}, 64'b11);
        run_done(200, "stall");

        // Full throughput: 16 samples accepted on consecutive cycles
        acc0 = 0; first_acc0 = -1;
        pkt_b.delete();
        for (int i = 0; i < 16; i++) pkt_b.push_back(8'($urandom));
        load_pkt(1'b0);
        expect_pkt(1'b0);
        run_done(200, "thru");
        check("thru_count", 64'(acc0), 64'd16);
        check("thru_span", 64'(last_acc0 - first_acc0), 64'd15);

        // Reset after two samples discards the partial word
        acc0 = 0;
        pkt_b = '{8'h91, 8'h92, 8'h93, 8'h94, 8'h95, 8'h96};
        load_pkt(1'b0);
        n = 0;
        while (acc0 < 2 && n < 30) begin
            step();
            n++;
        end
        check("mid_reset_setup_timeout", 64'(n >= 30), 64'd0);
        do_reset();
        cfg_burst = BW'(1);
        pkt_b = '{8'h12, 8'h34, 8'h56, 8'h78};
        load_pkt(1'b0);
        exp_q.push_back({1'b0, 1'b1, 32'h12345678});
        run_done(200, "post_reset");

        // Randomized two-source traffic
        for (int ph = 0; ph < 6; ph++) begin
            do_reset();
            bubbles = 1'b1;
            rdy_pct = $urandom_range(50, 100);
            b = $urandom_range(0, 15);
            eff = (b == 0) ? 1 : b;
            cfg_burst = BW'(b);
            gen_pkts(1'b0, eff * $urandom_range(1, 2));
            gen_pkts(1'b1, eff * $urandom_range(0, 2));
            model_run(eff);
            run_done(8000, "rand");
        end
        bubbles = 1'b0;
        rdy_pct = 100;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/zip_pkt_scheduler.md
ZIP_PKT_SCHEDULER -- requirements
Module: zip_pkt_scheduler

Interface
REQ-001 Parameter: MAX_BURST, 15, largest packets-per-grant accepted on cfg_burst (cfg_burst width = $clog2(MAX_BURST+1)).
REQ-002 Ports: clk  in  1  sole clock, all logic on rising edge.
REQ-003 Ports: reset_n  in  1  asynchronous, active-low reset.
REQ-004 Ports: cfg_burst  in  $clog2(MAX_BURST+1)  packets per grant, sampled only when a grant is issued; 0 behaves as 1.
REQ-005 Ports: s0_tdata/s1_tdata  in  32  sample, I=[31:16], Q=[15:0]; s0_tlast/s1_tlast, s0_tvalid/s1_tvalid  in  1; s0_tready/s1_tready  out  1.
REQ-006 Ports: o_tdata  out  32  four packed symbols; o_tlast, o_tvalid  out  1; o_tready  in  1; o_tdest  out  1  source id of word.
REQ-007 Ports: o_grant  out  2  one-hot current grant (00 = none).

Function
REQ-008 Symbol byte SHALL be {I[15:12], Q[15:12]}; byte k (0..3) of a word lands in o_tdata[31-8k -: 8].
REQ-009 FSM states SHALL be IDLE, PACK, DRAIN.
REQ-010 IDLE: if any sX_tvalid, grant the requester that is not last_src if it is valid, else the other; latch burst count from cfg_burst; go PACK next cycle; no input accepted in IDLE.
REQ-011 Only the granted sX_tready may be high; ungranted tready SHALL be 0.
REQ-012 PACK: granted sX_tready = ~o_tvalid | o_tready; each accepted sample writes its byte at index idx, idx increments.
REQ-013 When 4th byte (idx=3) or a tlast sample is accepted, the word SHALL be loaded into the output register with o_tvalid=1 on the next cycle (latency 1 cycle), idx returns to 0.
REQ-014 Word closed by tlast before idx=3 SHALL have unwritten bytes zeroed; o_tlast=1 iff word closed by tlast.
REQ-015 o_tdata/o_tlast/o_tdest SHALL stay stable while o_tvalid & ~o_tready; o_tvalid drops the cycle after handshake unless a new word loads the same cycle.
REQ-016 Each accepted tlast decrements the burst count; at zero go DRAIN, accepting no further input.
REQ-017 DRAIN: when output register empty or handshaking, set last_src = granted source, clear o_grant, go IDLE.
REQ-018 Grant SHALL never change mid-packet; switching occurs only via DRAIN->IDLE.
REQ-019 Both requesters valid in IDLE with no prior grant: source 0 wins (last_src resets to 1).
REQ-020 Simultaneous output handshake and new word load SHALL keep o_tvalid=1 with no bubble; full throughput = 1 sample/cycle.
REQ-021 o_tdest SHALL equal granted source index captured at word load.

Reset
REQ-022 reset_n low SHALL asynchronously force: state IDLE, o_tvalid=0, o_tlast=0, o_tdata=0, o_tdest=0, o_grant=00, s0/s1_tready=0, idx=0, burst count=0, last_src=1.
REQ-023 Reset mid-packet SHALL discard the partial word and pending output without emitting it.
REQ-024 Release of reset_n SHALL take effect on the first clk edge after deassertion; no output until a new grant.

Verification
REQ-025 s0 sends 8 samples I=0xA000..,Q=0x5000.. (bytes A5 each), tlast on 8th, o_tready=1, cfg_burst=1 -> two words 0xA5A5A5A5, second with o_tlast=1, o_tdest=0, then o_grant=00.
REQ-026 s1 packet of 6 samples bytes 11,22,33,44,55,66 tlast on 6th -> 0x11223344 (tlast 0), 0x55660000 (tlast 1), o_tdest=1.
REQ-027 Both valid, cfg_burst=2, each sends 1-sample packets -> grant order s0,s0 (2 packets), then s1,s1; o_tdest sequence 0,0,1,1.
REQ-028 o_tready held 0 for 5 cycles with word pending -> o_tdata stable, granted tready=0, no samples lost; release -> stream resumes without bubble.
REQ-029 reset_n pulsed low after 2 samples of s0 packet -> all outputs zero immediately, no partial word emitted; next packet packs from byte 0.
REQ-030 cfg_burst=0 -> behaves as 1: grant released after first tlast.
